// File: rtl/biu_fifo_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : biu_fifo_slave_pkg
//  Purpose  : Register map offsets, STATUS/CTRL bit positions and the register
//             select decode shared by the buffered bus slave.
//  Revision : 1.0  initial release
// ============================================================================
package biu_fifo_slave_pkg;

  // Byte offsets of the registers inside the 16-byte window
  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_UNF_BIT    = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 8;

  // CTRL bit positions
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  // Map a word-aligned window offset onto a register select; low bits ignored
  function automatic reg_sel_e decode_reg(input logic [3:0] ofs);
    logic [3:0] aligned;
    aligned = {ofs[3:2], 2'b00};
    case (aligned)
      OFS_DATA:   return REG_DATA;
      OFS_STATUS: return REG_STATUS;
      OFS_CTRL:   return REG_CTRL;
      default:    return REG_RSVD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/biu_fifo_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with push/pop/flush, full/empty/count and a
//             zero-valued head when empty. A full FIFO still accepts a push
//             when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff;
  logic             push_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  // Flush wins over both push and pop; an empty FIFO never pops
  assign pop_eff  = pop_i & ~empty_o & ~flush_i;
  assign push_eff = push_i & ~flush_i & (~full_o | pop_eff);
  assign drop_o   = push_i & ~flush_i & full_o & ~pop_eff;
  assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer/count values; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Pointer and count registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/biu_fifo_slave.sv
`default_nettype none
// ============================================================================
//  Module   : biu_fifo_slave
//  Purpose  : Memory-mapped bus responder. DATA writes push into a FIFO that a
//             local stream drains; STATUS/CTRL give readback and control.
//             Every hit completes with a registered one-cycle o_ready pulse.
//  Revision : 1.0  initial release
// ============================================================================
module biu_fifo_slave
  import biu_fifo_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hc000_0010,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  input  logic                  i_rnw,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_st_data,
  output logic                  o_st_valid,
  input  logic                  i_st_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  hit;
  reg_sel_e              sel;
  logic                  wr_data, rd_data, wr_ctrl;
  logic                  flush, clear;
  logic                  fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  ready_d, ready_q;
  logic                  ovf_q, unf_q;

  // Window decode: offset from base must be below 16 bytes
  assign offset  = i_address - BASE_ADDR;
  assign hit     = i_en & (i_address >= BASE_ADDR) & (offset < ADDR_WIDTH'(16));
  assign sel     = decode_reg(offset[3:0]);
  assign wr_data = hit & ~i_rnw & (sel == REG_DATA);
  assign rd_data = hit &  i_rnw & (sel == REG_DATA);
  assign wr_ctrl = hit & ~i_rnw & (sel == REG_CTRL);
  assign flush   = wr_ctrl & i_data[CTRL_FLUSH_BIT];
  assign clear   = wr_ctrl & i_data[CTRL_CLEAR_BIT];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (wr_data),
    .pop_i   (i_st_ready),
    .flush_i (flush),
    .data_i  (i_data),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  assign o_st_data  = fifo_head;
  assign o_st_valid = ~fifo_empty;

  // Assemble the STATUS word from live FIFO state and sticky flags
  always_comb begin
    status_word                         = '0;
    status_word[ST_COUNT_LSB +: CW]     = fifo_count;
    status_word[ST_OVF_BIT]             = ovf_q;
    status_word[ST_UNF_BIT]             = unf_q;
    status_word[ST_FULL_BIT]            = fifo_full;
    status_word[ST_EMPTY_BIT]           = fifo_empty;
  end

  // Read mux and response next-state; writes complete with zero data
  always_comb begin
    ready_d = hit;
    rdata_d = '0;
    if (hit && i_rnw) begin
      case (sel)
        REG_DATA:   rdata_d = fifo_head;
        REG_STATUS: rdata_d = status_word;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Registered access response; reset cancels any completion in flight
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ready = ready_q;
  assign o_data  = rdata_q;

  // Sticky overflow/underflow flags; a clear beats a same-cycle set
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (fifo_drop)              ovf_q <= 1'b1;
      if (rd_data && fifo_empty)  unf_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biu_fifo_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_biu_fifo_slave
//  Purpose  : Self-checking bench for biu_fifo_slave: queue-based reference
//             model compared every cycle, directed scenarios with literal
//             expectations, then randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_biu_fifo_slave;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hc000_0010;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en, rnw, st_ready;
  logic [31:0] addr, wdata;
  logic [31:0] o_data, o_st_data;
  logic        o_ready, o_st_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  biu_fifo_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_en       (en),
    .i_rnw      (rnw),
    .i_address  (addr),
    .i_data     (wdata),
    .o_data     (o_data),
    .o_ready    (o_ready),
    .o_st_data  (o_st_data),
    .o_st_valid (o_st_valid),
    .i_st_ready (st_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue + sticky flags ----------------
  logic [31:0] mq[$];
  bit          m_ovf = 0, m_unf = 0, m_valid = 0;
  logic        exp_ready;
  logic [31:0] exp_data;

  always @(posedge clk) begin : model
    automatic bit          popf;
    automatic bit          hit;
    automatic logic [31:0] off;
    automatic int          reg_idx;
    if (!n_rst) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_valid = 1;
      exp_ready = 0; exp_data = 0;
    end else begin
      popf    = (mq.size() > 0) && st_ready;
      off     = addr - BASE;
      hit     = en && (addr >= BASE) && (off < 32'd16);
      reg_idx = int'(off[3:2]);
      exp_ready = hit;
      exp_data  = 0;
      if (hit && rnw) begin
        if (reg_idx == 0) begin
          if (mq.size() > 0) exp_data = mq[0];
          else m_unf = 1;
        end else if (reg_idx == 1) begin
          exp_data = (32'(mq.size()) << 8) | (32'(m_ovf) << 3) | (32'(m_unf) << 2)
                   | (32'(mq.size() == DEPTH) << 1) | 32'(mq.size() == 0);
        end
      end
      if (hit && !rnw && reg_idx == 2 && wdata[0]) begin
        mq.delete();
        popf = 0;
      end
      if (popf) void'(mq.pop_front());
      if (hit && !rnw && reg_idx == 0) begin
        if (mq.size() < DEPTH) mq.push_back(wdata);
        else m_ovf = 1;
      end
      if (hit && !rnw && reg_idx == 2 && wdata[1]) begin
        m_ovf = 0; m_unf = 0;
      end
    end
    #1;
    if (m_valid) begin
      check("ready",    {31'b0, o_ready},    {31'b0, exp_ready});
      check("rdata",    o_data,              exp_data);
      check("st_valid", {31'b0, o_st_valid}, {31'b0, mq.size() > 0});
      check("st_data",  o_st_data,           (mq.size() > 0) ? mq[0] : 32'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit e, input bit r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; rnw = r; addr = a; wdata = d;
  endtask

  task automatic access(input bit r, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic rdy);
    drive(1'b1, r, a, d);
    @(negedge clk);
    rd  = o_data;
    rdy = o_ready;
    en  = 1'b0;
  endtask

  logic [31:0] rd;
  logic        rdy;

  initial begin
    n_rst = 1'b0; en = 1'b0; rnw = 1'b0; addr = '0; wdata = '0; st_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",    {31'b0, o_ready},    32'h0);
    check("rst_data",     o_data,              32'h0);
    check("rst_st_valid", {31'b0, o_st_valid}, 32'h0);
    check("rst_st_data",  o_st_data,           32'h0);
    n_rst = 1'b1;

    // 1: STATUS after reset shows empty
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t1_ready",  {31'b0, rdy}, 32'h1);
    check("t1_status", rd, 32'h0000_0001);

    // 2: three back-to-back pushes, peek, then stream drain in order
    drive(1'b1, 1'b0, BASE, 32'hA5A5_0001);
    drive(1'b1, 1'b0, BASE, 32'hA5A5_0002);
    drive(1'b1, 1'b0, BASE, 32'hA5A5_0003);
    drive(1'b0, 1'b0, 0, 0);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t2_status", rd, 32'h0000_0300);
    access(1'b1, BASE, 0, rd, rdy);
    check("t2_peek", rd, 32'hA5A5_0001);
    @(negedge clk); st_ready = 1'b1;
    check("t2_st0", o_st_data, 32'hA5A5_0001);
    @(negedge clk);
    check("t2_st1", o_st_data, 32'hA5A5_0002);
    @(negedge clk);
    check("t2_st2", o_st_data, 32'hA5A5_0003);
    @(negedge clk); st_ready = 1'b0;
    check("t2_drained", {31'b0, o_st_valid}, 32'h0);

    // 3: fill, overflow drop, clear ovf
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, BASE, 32'h1000_0000 + i);
    drive(1'b1, 1'b0, BASE, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 0, 0);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t3_status_ovf", rd, 32'h0000_080A);
    access(1'b0, BASE + 8, 32'h2, rd, rdy);
    check("t3_ctrl_wr_data", rd, 32'h0);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t3_status_clr", rd, 32'h0000_0802);

    // 4: full FIFO, push with simultaneous pop is accepted
    @(negedge clk);
    en = 1'b1; rnw = 1'b0; addr = BASE; wdata = 32'h1234_5678; st_ready = 1'b1;
    @(negedge clk);
    en = 1'b0; st_ready = 1'b0;
    check("t4_head", o_st_data, 32'h1000_0001);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t4_status", rd, 32'h0000_0802);

    // 5: out-of-window accesses, flush, underflow read
    access(1'b0, BASE - 4, 32'h5, rd, rdy);
    check("t5_below_rdy", {31'b0, rdy}, 32'h0);
    access(1'b1, BASE + 32'h10, 0, rd, rdy);
    check("t5_above_rdy", {31'b0, rdy}, 32'h0);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t5_status", rd, 32'h0000_0802);
    access(1'b0, BASE + 8, 32'h1, rd, rdy);
    access(1'b1, BASE, 0, rd, rdy);
    check("t5_unf_rdy",  {31'b0, rdy}, 32'h1);
    check("t5_unf_data", rd, 32'h0);
    access(1'b1, BASE + 4, 0, rd, rdy);
    check("t5_status_unf", rd, 32'h0000_0005);
    access(1'b1, BASE + 12, 0, rd, rdy);
    check("t5_rsvd", rd, 32'h0);

    // 6: flush beats stream pop; reset mid-stream cancels pending access
    access(1'b0, BASE + 8, 32'h3, rd, rdy);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, BASE, 32'h6000_0000 + i);
    drive(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    en = 1'b1; rnw = 1'b0; addr = BASE + 8; wdata = 32'h1; st_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("t6_flushed", {31'b0, o_st_valid}, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, BASE, 32'h7000_0000 + i);
    @(negedge clk);
    n_rst = 1'b0; en = 1'b1; rnw = 1'b1; addr = BASE + 4;
    @(negedge clk);
    check("t6_rst_ready",    {31'b0, o_ready},    32'h0);
    check("t6_rst_data",     o_data,              32'h0);
    check("t6_rst_st_valid", {31'b0, o_st_valid}, 32'h0);
    check("t6_rst_st_data",  o_st_data,           32'h0);
    n_rst = 1'b1; en = 1'b0; st_ready = 1'b0;

    // Randomized traffic checked by the model every cycle
    repeat (3000) begin
      @(negedge clk);
      n_rst    = ($urandom_range(0, 299) != 0);
      en       = ($urandom_range(0, 2) != 0);
      st_ready = ($urandom_range(0, 2) == 0);
      wdata    = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          addr = BASE + $urandom_range(0, 3);
          rnw  = ($urandom_range(0, 3) == 0);
        end
        5: begin addr = BASE + 4;  rnw = 1'b1; end
        6: begin
          addr     = BASE + 8;
          rnw      = $urandom_range(0, 1) != 0;
          wdata[0] = ($urandom_range(0, 5) == 0);
          wdata[1] = ($urandom_range(0, 2) == 0);
        end
        7: begin addr = BASE + 12 + $urandom_range(0, 3); rnw = $urandom_range(0, 1) != 0; end
        8: begin addr = BASE - 4 + $urandom_range(0, 3);  rnw = $urandom_range(0, 1) != 0; end
        default: begin addr = BASE + 16 + $urandom_range(0, 3); rnw = $urandom_range(0, 1) != 0; end
      endcase
    end
    @(negedge clk);
    n_rst = 1'b1; en = 1'b0; st_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
